bram_tdp_param: RTL and testbench

Parametrised true-dual-port block RAM with byte-lane write enables. It has a configurable read latency (1 or 2 cycles) and flags cross-port address collisions. After reset, an internal clear engine zeroes every word before the RAM accepts user traffic. It replaces fixed-geometry dual-port wrappers in the pipeline's instruction, state and TLB storage, and gives both ports identical capability.

---
 rtl/bram_tdp_param.sv | 143 ++++++++++++++
 tb/tb_bram_tdp_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_tdp_param.sv
// True-dual-port block RAM with per-lane write enables, read-first ports, 1- or 2-cycle read latency,
// same-address collision flag, and a post-reset clear engine that zeroes every word before user traffic.
module bram_tdp_param #(
  parameter int DATA_W         = 36,
  parameter int ADDR_W         = 10,
  parameter int LANE_W         = 9,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       io_portA_en,
  input  logic [DATA_W/LANE_W-1:0]   io_portA_writeEn,
  input  logic [ADDR_W-1:0]          io_portA_addr,
  input  logic [DATA_W-1:0]          io_portA_dataIn,
  output logic [DATA_W-1:0]          io_portA_dataOut,
  output logic                       io_portA_valid,
  input  logic                       io_portB_en,
  input  logic [DATA_W/LANE_W-1:0]   io_portB_writeEn,
  input  logic [ADDR_W-1:0]          io_portB_addr,
  input  logic [DATA_W-1:0]          io_portB_dataIn,
  output logic [DATA_W-1:0]          io_portB_dataOut,
  output logic                       io_portB_valid,
  output logic                       io_ready,
  output logic                       io_collision
);

  localparam int NL    = DATA_W / LANE_W;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_d;
  logic [ADDR_W:0] clr_cnt, clr_cnt_d;
  logic            clr_we;
  logic            ready;

  // Index 0 is port A, index 1 is port B.
  logic [1:0]        acc;
  logic [NL-1:0]     we   [2];
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] din  [2];

  logic [DATA_W-1:0] rd_q    [2];
  logic [1:0]        rd_vld;
  logic [DATA_W-1:0] out_q   [2];
  logic [1:0]        out_vld;
  logic              coll_q;

  logic [DATA_W-1:0] mem [DEPTH];

  assign acc     = {ready & io_portB_en, ready & io_portA_en};
  assign we[0]   = io_portA_writeEn;
  assign we[1]   = io_portB_writeEn;
  assign addr[0] = io_portA_addr;
  assign addr[1] = io_portB_addr;
  assign din[0]  = io_portA_dataIn;
  assign din[1]  = io_portB_dataIn;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_d;
      clr_cnt <= clr_cnt_d;
      ready   <= (state_d == RUN);
    end
  end

  // The extra counter bit flags the step past the last address, so no wrap compare is needed.
  always_comb begin
    state_d   = state;
    clr_cnt_d = clr_cnt;
    clr_we    = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt + CNT_ONE;
        if (clr_cnt_d[ADDR_W]) state_d = RUN;
      end
      RUN: ;
      default: state_d = RUN;
    endcase
  end

  // NOTE: the array has no reset branch; reset cannot zero a block RAM, so the clear engine does it.
  always_ff @(posedge clock) begin
    if (clr_we) mem[clr_cnt[ADDR_W-1:0]] <= '0;
    // Port B is applied first so port A's lanes overwrite it on a same-address collision.
    for (int p = 1; p >= 0; p--) begin
      for (int l = 0; l < NL; l++) begin
        if (acc[p] && we[p][l])
          mem[addr[p]][l*LANE_W +: LANE_W] <= din[p][l*LANE_W +: LANE_W];
      end
    end
  end

  // Reads sample the array before this edge's writes land, which gives read-first behaviour.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q[0] <= '0;
      rd_q[1] <= '0;
      rd_vld  <= '0;
      coll_q  <= 1'b0;
    end else begin
      rd_vld <= acc;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) rd_q[p] <= mem[addr[p]];
      end
      coll_q <= acc[0] & acc[1] & (addr[0] == addr[1]) & ((|we[0]) | (|we[1]));
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clock) begin
      if (reset) begin
        out_q[0] <= '0;
        out_q[1] <= '0;
        out_vld  <= '0;
      end else begin
        out_vld <= rd_vld;
        for (int p = 0; p < 2; p++) begin
          if (rd_vld[p]) out_q[p] <= rd_q[p];
        end
      end
    end
  end else begin : g_no_out_reg
    assign out_q[0] = rd_q[0];
    assign out_q[1] = rd_q[1];
    assign out_vld  = rd_vld;
  end

  assign io_portA_dataOut = out_q[0];
  assign io_portB_dataOut = out_q[1];
  assign io_portA_valid   = out_vld[0];
  assign io_portB_valid   = out_vld[1];
  assign io_ready         = ready;
  assign io_collision     = coll_q;

endmodule

// File: tb/tb_bram_tdp_param.sv
// Directed bench for bram_tdp_param: one instance with latency 1 and one with latency 2 share all inputs.
module tb_bram_tdp_param;

  logic        clock;
  logic        reset;
  logic        a_en, b_en;
  logic [3:0]  a_we, b_we;
  logic [9:0]  a_addr, b_addr;
  logic [35:0] a_din, b_din;

  logic [35:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic        a_vld0, b_vld0, a_vld1, b_vld1;
  logic        ready0, ready1, coll0, coll1;

  int n_cmp = 0;
  int n_bad = 0;

  bram_tdp_param #(.OUT_REG(0)) u_dut (
    .clock(clock), .reset(reset),
    .io_portA_en(a_en), .io_portA_writeEn(a_we), .io_portA_addr(a_addr),
    .io_portA_dataIn(a_din), .io_portA_dataOut(a_dout0), .io_portA_valid(a_vld0),
    .io_portB_en(b_en), .io_portB_writeEn(b_we), .io_portB_addr(b_addr),
    .io_portB_dataIn(b_din), .io_portB_dataOut(b_dout0), .io_portB_valid(b_vld0),
    .io_ready(ready0), .io_collision(coll0)
  );

  bram_tdp_param #(.OUT_REG(1)) u_dut_r (
    .clock(clock), .reset(reset),
    .io_portA_en(a_en), .io_portA_writeEn(a_we), .io_portA_addr(a_addr),
    .io_portA_dataIn(a_din), .io_portA_dataOut(a_dout1), .io_portA_valid(a_vld1),
    .io_portB_en(b_en), .io_portB_writeEn(b_we), .io_portB_addr(b_addr),
    .io_portB_dataIn(b_din), .io_portB_dataOut(b_dout1), .io_portB_valid(b_vld1),
    .io_ready(ready1), .io_collision(coll1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  task automatic set_a(input logic [9:0] ad, input logic [3:0] w, input logic [35:0] d);
    a_en = 1'b1; a_we = w; a_addr = ad; a_din = d;
  endtask

  task automatic set_b(input logic [9:0] ad, input logic [3:0] w, input logic [35:0] d);
    b_en = 1'b1; b_we = w; b_addr = ad; b_din = d;
  endtask

  // Counts edges after reset release until io_ready reads 1; bounded so a stuck clear still ends.
  task automatic wait_ready(output int cycles, output int stray);
    cycles = 0;
    stray  = 0;
    while (cycles < 2000) begin
      tick();
      cycles++;
      if (a_vld0 || b_vld0 || a_vld1 || b_vld1) stray++;
      if (ready0) break;
    end
  endtask

  function automatic logic [35:0] pat(input int i);
    logic [8:0] lane;
    lane = 9'(i * 3 + 1);
    return {lane, lane, lane, lane};
  endfunction

  int cycles, stray;

  initial begin
    idle();
    reset = 1'b1;
    tick();
    check("rst_ready", ready0, 1'b0);
    check("rst_a_valid", a_vld0, 1'b0);
    check("rst_b_valid", b_vld0, 1'b0);
    check("rst_a_dout", a_dout0, 36'h0);
    check("rst_coll", coll0, 1'b0);
    check("rst_a_valid_r", a_vld1, 1'b0);
    check("rst_a_dout_r", a_dout1, 36'h0);
    reset = 1'b0;

    // Requests during the clear must be ignored; a leaked write to addr 0 would survive the clear.
    set_a(10'h000, 4'hF, 36'hFFFFFFFFF);
    wait_ready(cycles, stray);
    idle();
    check("clear_rise", cycles, 1024);
    check("clear_valid", stray, 0);
    check("clear_ready_r", ready1, 1'b1);

    // Test 1: cleared contents read back as zero.
    set_a(10'h3FF, 4'h0, 36'h0);
    set_b(10'h000, 4'h0, 36'h0);
    tick();
    idle();
    check("t1_a_valid", a_vld0, 1'b1);
    check("t1_a_dout", a_dout0, 36'h0);
    check("t1_b_valid", b_vld0, 1'b1);
    check("t1_b_dout", b_dout0, 36'h0);
    check("t1_a_valid_r_early", a_vld1, 1'b0);
    tick();
    check("t1_a_valid_r", a_vld1, 1'b1);
    check("t1_a_dout_r", a_dout1, 36'h0);
    check("t1_a_valid_drop", a_vld0, 1'b0);

    // Test 2: partial-lane write, read-first on the second write.
    set_a(10'd5, 4'hF, 36'hFFFFFFFFF);
    tick();
    check("t2_w1_dout", a_dout0, 36'h0);
    set_a(10'd5, 4'b0101, 36'h0);
    tick();
    check("t2_w2_readfirst", a_dout0, 36'hFFFFFFFFF);
    idle();
    set_b(10'd5, 4'h0, 36'h0);
    tick();
    idle();
    check("t2_lanes", b_dout0, {9'h1FF, 9'h000, 9'h1FF, 9'h000});

    // Test 3: write/write collision, A wins the shared lane.
    set_a(10'd7, 4'hF, 36'h0ABCDEF01);
    tick();
    set_a(10'd7, 4'hF, 36'h111111111);
    set_b(10'd7, 4'b1000, 36'h222222222);
    tick();
    check("t3_coll", coll0, 1'b1);
    check("t3_coll_r", coll1, 1'b1);
    check("t3_a_old", a_dout0, 36'h0ABCDEF01);
    check("t3_b_old", b_dout0, 36'h0ABCDEF01);
    idle();
    set_a(10'd7, 4'h0, 36'h0);
    tick();
    check("t3_coll_pulse", coll0, 1'b0);
    check("t3_stored", a_dout0, 36'h111111111);

    // Disjoint lanes on a collision: each port's lane is kept.
    set_a(10'd8, 4'b0001, 36'h000000033);
    set_b(10'd8, 4'b1000, 36'hA00000000);
    tick();
    check("t3b_coll", coll0, 1'b1);
    check("t3b_a_old", a_dout0, 36'h0);
    idle();
    set_b(10'd8, 4'h0, 36'h0);
    tick();
    check("t3b_stored", b_dout0, 36'hA00000033);
    check("t3b_coll_pulse", coll0, 1'b0);

    // Read on A against a write on B at the same address is still a collision.
    set_a(10'd12, 4'h0, 36'h0);
    set_b(10'd12, 4'hF, 36'h5A5A5A5A5);
    tick();
    check("t3c_coll", coll0, 1'b1);
    check("t3c_a_old", a_dout0, 36'h0);
    idle();
    set_a(10'd12, 4'h0, 36'h0);
    tick();
    check("t3c_stored", a_dout0, 36'h5A5A5A5A5);

    // Test 4: read/read at the same address is not a collision.
    set_a(10'd9, 4'hF, 36'h123456789);
    tick();
    set_a(10'd9, 4'h0, 36'h0);
    set_b(10'd9, 4'h0, 36'h0);
    tick();
    check("t4_coll", coll0, 1'b0);
    check("t4_a_dout", a_dout0, 36'h123456789);
    check("t4_b_dout", b_dout0, 36'h123456789);
    idle();
    tick();
    check("t4_valid_idle", a_vld0, 1'b0);
    check("t4_dout_hold", a_dout0, 36'h123456789);

    // Test 5: streaming reads; latency 1 on u_dut, latency 2 on u_dut_r.
    for (int i = 0; i < 8; i++) begin
      idle();
      set_b(10'(i), 4'hF, pat(i));
      tick();
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) set_a(10'(i), 4'h0, 36'h0);
      else idle();
      tick();
      check($sformatf("t5_valid_%0d", i), a_vld0, (i < 8));
      if (i < 8) check($sformatf("t5_dout_%0d", i), a_dout0, pat(i));
      check($sformatf("t5_valid_r_%0d", i), a_vld1, (i >= 1 && i <= 8));
      if (i >= 1 && i <= 8) check($sformatf("t5_dout_r_%0d", i), a_dout1, pat(i - 1));
    end
    idle();

    // Test 6: a read in flight on the latency-2 instance is flushed by reset.
    set_a(10'd3, 4'h0, 36'h0);
    tick();
    check("t6_accept", a_vld0, 1'b1);
    check("t6_inflight", a_vld1, 1'b0);
    idle();
    reset = 1'b1;
    tick();
    check("t6_flush_valid_r", a_vld1, 1'b0);
    check("t6_flush_dout_r", a_dout1, 36'h0);
    check("t6_flush_dout", a_dout0, 36'h0);
    check("t6_flush_ready", ready0, 1'b0);
    reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (a_vld0 || b_vld0 || a_vld1 || b_vld1 || ready0) stray++;
    end
    check("t6_partial_clear", stray, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_ready(cycles, stray);
    check("t6_restart_rise", cycles, 1024);
    check("t6_restart_valid", stray, 0);
    set_a(10'd3, 4'h0, 36'h0);
    tick();
    idle();
    check("t6_recleared", a_dout0, 36'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
